// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider, one quotient bit per clock.
// Operands are captured on an accepted start. WIDTH restoring steps run on a
// 2*WIDTH-bit AQ register, then a FIX cycle applies the sign correction.
// The result is presented with a registered one-cycle result_valid pulse.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement negation modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  // Magnitude of an operand. With the modulo wrap, -2^(WIDTH-1) maps to
  // 2^(WIDTH-1), which is correct when read as an unsigned value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  state_t             state;
  state_t             next_state;
  logic [2*WIDTH-1:0] aq;
  logic [WIDTH-1:0]   div_mag;
  logic [CNT_W-1:0]   count;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               last_step;
  logic               zero_div;
  logic [WIDTH:0]     a_shift;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   step_a;
  logic [WIDTH-1:0]   step_q;

  // A start is taken only in IDLE, and never while the previous result is
  // still being presented.
  assign accept    = (state == IDLE) && start && !result_valid;
  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign zero_div  = (divisor == {WIDTH{1'b0}});

  // One restoring step. The partial remainder is widened to WIDTH+1 bits so
  // that the shifted-out MSB takes part in the compare for large divisors.
  always_comb begin
    a_shift = aq[2*WIDTH-1:WIDTH-1];
    diff    = a_shift - {1'b0, div_mag};
    if (diff[WIDTH]) begin
      step_a = a_shift[WIDTH-1:0];
    end else begin
      step_a = diff[WIDTH-1:0];
    end
    step_q = {aq[WIDTH-2:0], ~diff[WIDTH]};
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (zero_div) begin
            next_state = DONE;
          end else begin
            next_state = RUN;
          end
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          next_state = FIX;
        end else begin
          next_state = RUN;
        end
      end
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and registered status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aq           <= {(2*WIDTH){1'b0}};
      div_mag      <= {WIDTH{1'b0}};
      count        <= {CNT_W{1'b0}};
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      quotient     <= {WIDTH{1'b0}};
      remainder    <= {WIDTH{1'b0}};
      div_by_zero  <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      busy         <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (accept && zero_div) begin
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b1;
          end else if (accept) begin
            aq      <= {{WIDTH{1'b0}}, magnitude(dividend, is_signed)};
            div_mag <= magnitude(divisor, is_signed);
            neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed & dividend[WIDTH-1];
            count   <= {CNT_W{1'b0}};
          end else begin
            aq <= aq;
          end
        end
        RUN: begin
          aq    <= {step_a, step_q};
          count <= count + CNT_W'(1);
        end
        FIX: begin
          quotient    <= neg_q ? negate(aq[WIDTH-1:0]) : aq[WIDTH-1:0];
          remainder   <= neg_r ? negate(aq[2*WIDTH-1:WIDTH]) : aq[2*WIDTH-1:WIDTH];
          div_by_zero <= 1'b0;
        end
        default: begin
          aq <= aq;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a queue scoreboard. The stimulus
// process pushes expected results; a monitor pops and checks on result_valid.
module tb_seq_divider;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             is_signed = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy),
    .result_valid(result_valid), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts cycles and checks every result against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result_valid=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency_cycle", cyc, e.exp_cyc);
      end
    end
  end

  // Drive one start pulse; E0 is the edge that samples it. When accepted, the
  // expected result is queued with the cycle in which it must appear.
  task automatic do_start(input logic sg, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                          input logic [WIDTH-1:0] er, input logic edz,
                          input bit accepted);
    exp_t e;
    @(posedge clock);
    #1;
    start = 1'b1;
    is_signed = sg;
    dividend = a;
    divisor = b;
    @(posedge clock);
    if (accepted) begin
      e.q = eq;
      e.r = er;
      e.dz = edz;
      e.exp_cyc = cyc + 1 + ((b == '0) ? 1 : WIDTH + 2);
      sb.push_back(e);
    end
    #1;
    start = 1'b0;
    is_signed = 1'($urandom);
    dividend = $urandom;
    divisor = $urandom;
  endtask

  // Wait (bounded) until every queued result has been seen.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d results pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Unsigned, signed and boundary divides.
    do_start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    #2;
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    wait_done("u100_7");
    repeat (3) @(negedge clock);
    chk("held_quotient", quotient, 32'd14);
    chk("held_remainder", remainder, 32'd2);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    do_start(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1);
    wait_done("sm100_7");
    do_start(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b1);
    wait_done("s100_m7");
    do_start(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    wait_done("div0");
    do_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_done("sovf");
    do_start(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    wait_done("umax_1");
    do_start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    wait_done("u80_max");
    do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b1);
    wait_done("umax_maxm1");
    do_start(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done("sm7_m2");
    do_start(1'b0, 32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b1);
    wait_done("u1e6_1e3");

    // Start while busy must be ignored and not queued.
    do_start(1'b0, 32'd1234, 32'd10, 32'd123, 32'd4, 1'b0, 1'b1);
    repeat (8) @(posedge clock);
    do_start(1'b0, 32'd99, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_done("busy_start");
    repeat (40) @(negedge clock);
    chk("no_queued_busy", {31'd0, busy}, 32'd0);
    chk("no_queued_quotient", quotient, 32'd123);

    // Reset in the middle of an operation discards it.
    do_start(1'b0, 32'd500, 32'd3, 32'd166, 32'd2, 1'b0, 1'b1);
    repeat (15) @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    do_start(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 1'b1);
    wait_done("after_rst");
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
